render_sequencer: RTL

RENDER_SEQUENCER -- requirements
Module: render_sequencer

---
 rtl/render_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/render_sequencer.sv
// Frame sequencer for a double-buffered renderer: clears the draw buffer, streams vertex
// indices to the vertex processor, issues triangles as vertices complete, and swaps on vsync.
module render_sequencer #(
  parameter int IDX_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_vertices,
  input  logic              vsync,
  output logic              clear_req,
  input  logic              clear_ack,
  output logic              vp_valid,
  output logic [IDX_W-1:0]  vp_idx,
  input  logic              vp_ready,
  input  logic              vp_done,
  output logic              rast_valid,
  output logic [IDX_W-1:0]  rast_base,
  input  logic              rast_ready,
  input  logic              rast_idle,
  output logic              draw_sel,
  output logic              disp_sel,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    RUN        = 3'd2,
    DRAIN      = 3'd3,
    WAIT_VSYNC = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0]   ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   THREE = IDX_W'(3);
  localparam logic [IDX_W+1:0]   THREE_W = (IDX_W+2)'(3);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   nv_q, nv_d;
  logic [IDX_W-1:0]   ntri_q, ntri_d;
  logic [IDX_W-1:0]   done_q, done_d;
  logic [IDX_W-1:0]   tri_q, tri_d;
  logic [IDX_W-1:0]   vp_idx_q, vp_idx_d;
  logic [IDX_W-1:0]   rast_base_q, rast_base_d;
  logic               vp_valid_q, vp_valid_d;
  logic               rast_valid_q, rast_valid_d;
  logic               clear_req_q, clear_req_d;
  logic               busy_q, busy_d;
  logic               draw_sel_q, draw_sel_d;
  logic               disp_sel_q, disp_sel_d;
  logic               frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic               vp_hs_s;
  logic               rast_hs_s;

  // Next-state, counter and output computation.
  always_comb begin
    state_d      = state_q;
    nv_d         = nv_q;
    ntri_d       = ntri_q;
    done_d       = done_q;
    tri_d        = tri_q;
    vp_idx_d     = vp_idx_q;
    rast_base_d  = rast_base_q;
    draw_sel_d   = draw_sel_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    vp_hs_s      = vp_valid_q & vp_ready;
    rast_hs_s    = rast_valid_q & rast_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          nv_d        = num_vertices;
          ntri_d      = num_vertices / THREE;
          done_d      = '0;
          tri_d       = '0;
          vp_idx_d    = '0;
          rast_base_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (clear_ack) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        if (vp_hs_s) begin
          vp_idx_d = vp_idx_q + ONE;
        end else begin
          vp_idx_d = vp_idx_q;
        end
        if (vp_done) begin
          done_d = done_q + ONE;
        end else begin
          done_d = done_q;
        end
        if (rast_hs_s) begin
          rast_base_d = rast_base_q + THREE;
          tri_d       = tri_q + ONE;
        end else begin
          rast_base_d = rast_base_q;
          tri_d       = tri_q;
        end
        // Same-cycle final handshakes are already folded into the _d values.
        if ((vp_idx_d == nv_q) && (done_d == nv_q) && (tri_d == ntri_q)) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (vp_done) begin
          done_d = done_q + ONE;
        end else begin
          done_d = done_q;
        end
        if (rast_idle) begin
          state_d = WAIT_VSYNC;
        end else begin
          state_d = DRAIN;
        end
      end
      WAIT_VSYNC: begin
        if (vsync) begin
          state_d      = IDLE;
          draw_sel_d   = ~draw_sel_q;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
        end else begin
          state_d = WAIT_VSYNC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Once offered, a triangle stays offered: done_cnt only grows until the handshake.
    vp_valid_d   = (state_d == RUN) && (vp_idx_d < nv_q);
    rast_valid_d = (state_d == RUN) && (tri_d < ntri_q) &&
                   ({2'b00, done_d} >= ({2'b00, rast_base_d} + THREE_W));
    clear_req_d  = (state_d == CLEAR);
    busy_d       = (state_d != IDLE);
    disp_sel_d   = ~draw_sel_d;
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nv_q         <= '0;
      ntri_q       <= '0;
      done_q       <= '0;
      tri_q        <= '0;
      vp_idx_q     <= '0;
      rast_base_q  <= '0;
      vp_valid_q   <= 1'b0;
      rast_valid_q <= 1'b0;
      clear_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      draw_sel_q   <= 1'b0;
      disp_sel_q   <= 1'b1;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      nv_q         <= nv_d;
      ntri_q       <= ntri_d;
      done_q       <= done_d;
      tri_q        <= tri_d;
      vp_idx_q     <= vp_idx_d;
      rast_base_q  <= rast_base_d;
      vp_valid_q   <= vp_valid_d;
      rast_valid_q <= rast_valid_d;
      clear_req_q  <= clear_req_d;
      busy_q       <= busy_d;
      draw_sel_q   <= draw_sel_d;
      disp_sel_q   <= disp_sel_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign clear_req  = clear_req_q;
  assign vp_valid   = vp_valid_q;
  assign vp_idx     = vp_idx_q;
  assign rast_valid = rast_valid_q;
  assign rast_base  = rast_base_q;
  assign draw_sel   = draw_sel_q;
  assign disp_sel   = disp_sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
